// File: rtl/phi_pkg.sv
// Shared definitions for the phi (SSA phi-node) selector block.
// Holds the default basic-block id width, the block-id type and the pair-count limit.
// Purely declarative; no logic.
package phi_pkg;

  // Default width of a basic-block identifier.
  localparam int PHI_BB_WIDTH = 32;

  // Largest supported number of (predecessor-block, value) pairs.
  localparam int PHI_MAX_PAIRS = 16;

  // Block identifier at the default width.
  typedef logic [PHI_BB_WIDTH-1:0] bb_id_t;

endpackage

// File: rtl/phi_match.sv
// Purpose: compares every predecessor block id against last_block, one match bit per pair.
// Latency: combinational, zero cycles.
// Backpressure: none; no handshake.
//
// Ports:
//   s          - packed predecessor ids, pair i at [i*BB_WIDTH +: BB_WIDTH]
//   last_block - id of the block control arrived from
//   match      - bit i high when pair i's id equals last_block over all bits
module phi_match import phi_pkg::*; #(
  parameter int NB_PAIR  = 2,
  parameter int BB_WIDTH = PHI_BB_WIDTH
) (
  input  logic [NB_PAIR*BB_WIDTH-1:0] s,
  input  logic [BB_WIDTH-1:0]         last_block,
  output logic [NB_PAIR-1:0]          match
);

  for (genvar i = 0; i < NB_PAIR; i++) begin : g_cmp
    assign match[i] = (s[i*BB_WIDTH +: BB_WIDTH] == last_block);
  end

endmodule

// File: rtl/phi.sv
// Purpose: phi-node value selector; picks the value whose predecessor id matches last_block.
// Latency: out/miss combinational; out_q registered one edge after en.
// Backpressure: none; en is a plain capture strobe, outputs carry no valid qualifier.
//
// Ports:
//   clk, rst   - clock and asynchronous active-low reset (clears out_q and err)
//   in         - packed candidate values, pair i at [i*WIDTH +: WIDTH]
//   s          - packed predecessor block ids, pair i at [i*BB_WIDTH +: BB_WIDTH]
//   last_block - id of the block control arrived from
//   en         - capture strobe for out_q (and the miss check)
//   out        - selected value (zero on miss), combinational
//   out_q      - registered selected value
//   miss       - no pair matches last_block, combinational
//   err        - sticky "captured on a miss" flag
//
// Build option: define PHI_MISS_CHECK_EN to build the sticky error register;
// otherwise err is tied low.
module phi import phi_pkg::*; #(
  parameter int NB_PAIR  = 2,
  parameter int WIDTH    = 8,
  parameter int BB_WIDTH = PHI_BB_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NB_PAIR*WIDTH-1:0]    in,
  input  logic [NB_PAIR*BB_WIDTH-1:0] s,
  input  logic [BB_WIDTH-1:0]         last_block,
  input  logic                        en,
  output logic [WIDTH-1:0]            out,
  output logic [WIDTH-1:0]            out_q,
  output logic                        miss,
  output logic                        err
);

  if (NB_PAIR < 1 || NB_PAIR > PHI_MAX_PAIRS) begin : g_bad_nb_pair
    $error("phi: NB_PAIR must be in 1..16");
  end

  logic [NB_PAIR-1:0] match;
  logic               hit;

  phi_match #(
    .NB_PAIR  (NB_PAIR),
    .BB_WIDTH (BB_WIDTH)
  ) u_match (
    .s          (s),
    .last_block (last_block),
    .match      (match)
  );

  // Priority select: the first match found scanning upward wins, so
  // duplicate ids resolve to the lowest index.
  always_comb begin
    out = '0;
    hit = 1'b0;
    for (int i = 0; i < NB_PAIR; i++) begin
      if (match[i] && !hit) begin
        out = in[i*WIDTH +: WIDTH];
        hit = 1'b1;
      end
    end
  end

  assign miss = ~hit;

  // out is already zero on a miss, so a capture during a miss loads zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
    end else if (en) begin
      out_q <= out;
    end
  end

`ifdef PHI_MISS_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (en && miss) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_phi.sv
// Directed bench for phi: a default (2 x 8-bit) instance and a 4 x 16-bit instance.
// Expected values are hand-computed constants.
// Optional build macro PHI_MISS_CHECK_EN selects the expected err behaviour.
module tb_phi;

`ifdef PHI_MISS_CHECK_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic clk;
  logic rst;

  // Instance A: NB_PAIR=2, WIDTH=8
  logic [15:0] in_a;
  logic [63:0] s_a;
  logic [31:0] lb_a;
  logic        en_a;
  logic [7:0]  out_a;
  logic [7:0]  outq_a;
  logic        miss_a;
  logic        err_a;

  // Instance B: NB_PAIR=4, WIDTH=16
  logic [63:0]  in_b;
  logic [127:0] s_b;
  logic [31:0]  lb_b;
  logic         en_b;
  logic [15:0]  out_b;
  logic [15:0]  outq_b;
  logic         miss_b;
  logic         err_b;

  int n_cmp;
  int n_fail;

  phi u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .in         (in_a),
    .s          (s_a),
    .last_block (lb_a),
    .en         (en_a),
    .out        (out_a),
    .out_q      (outq_a),
    .miss       (miss_a),
    .err        (err_a)
  );

  phi #(.NB_PAIR(4), .WIDTH(16), .BB_WIDTH(32)) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .in         (in_b),
    .s          (s_b),
    .last_block (lb_b),
    .en         (en_b),
    .out        (out_b),
    .out_q      (outq_b),
    .miss       (miss_b),
    .err        (err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst  = 1'b1;
    in_a = {8'hA5, 8'h00};
    s_a  = {32'd1, 32'd0};
    lb_a = 32'd1;
    en_a = 1'b0;
    in_b = '0;
    s_b  = '0;
    lb_b = 32'd0;
    en_b = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    n_cmp++; if (outq_a !== 8'h00) begin n_fail++; $display("FAIL reset_outq_a: got %h want 00", outq_a); end
    n_cmp++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL reset_err_a: got %b want 0", err_a); end
    n_cmp++; if (outq_b !== 16'h0000) begin n_fail++; $display("FAIL reset_outq_b: got %h want 0000", outq_b); end
    // combinational path works while reset is asserted
    n_cmp++; if (out_a !== 8'hA5) begin n_fail++; $display("FAIL reset_comb_out: got %h want a5", out_a); end
    n_cmp++; if (miss_a !== 1'b0) begin n_fail++; $display("FAIL reset_comb_miss: got %b want 0", miss_a); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_select();
    @(negedge clk);
    lb_a = 32'd0;
    #1;
    n_cmp++; if (out_a !== 8'h00) begin n_fail++; $display("FAIL sel_lb0_out: got %h want 00", out_a); end
    n_cmp++; if (miss_a !== 1'b0) begin n_fail++; $display("FAIL sel_lb0_miss: got %b want 0", miss_a); end
    lb_a = 32'd1;
    #1;
    n_cmp++; if (out_a !== 8'hA5) begin n_fail++; $display("FAIL sel_lb1_out: got %h want a5", out_a); end
    n_cmp++; if (miss_a !== 1'b0) begin n_fail++; $display("FAIL sel_lb1_miss: got %b want 0", miss_a); end
  endtask

  task automatic test_capture();
    @(negedge clk);
    lb_a = 32'd1;
    en_a = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (outq_a !== 8'hA5) begin n_fail++; $display("FAIL cap_load: got %h want a5", outq_a); end
    @(negedge clk);
    en_a = 1'b0;
    in_a = {8'h3C, 8'h00};
    #1;
    n_cmp++; if (out_a !== 8'h3C) begin n_fail++; $display("FAIL cap_comb_new: got %h want 3c", out_a); end
    @(posedge clk); #1;
    n_cmp++; if (outq_a !== 8'hA5) begin n_fail++; $display("FAIL cap_hold1: got %h want a5", outq_a); end
    @(posedge clk); #1;
    n_cmp++; if (outq_a !== 8'hA5) begin n_fail++; $display("FAIL cap_hold2: got %h want a5", outq_a); end
  endtask

  task automatic test_miss();
    @(negedge clk);
    in_a = {8'hA5, 8'h00};
    lb_a = 32'd7;
    en_a = 1'b1;
    #1;
    n_cmp++; if (miss_a !== 1'b1) begin n_fail++; $display("FAIL miss_flag: got %b want 1", miss_a); end
    n_cmp++; if (out_a !== 8'h00) begin n_fail++; $display("FAIL miss_out: got %h want 00", out_a); end
    n_cmp++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL miss_err_pre: got %b want 0", err_a); end
    @(posedge clk); #1;
    n_cmp++; if (outq_a !== 8'h00) begin n_fail++; $display("FAIL miss_outq: got %h want 00", outq_a); end
    n_cmp++; if (err_a !== ERR_ON) begin n_fail++; $display("FAIL miss_err: got %b want %b", err_a, ERR_ON); end
    // sticky: clearing the miss does not clear err
    @(negedge clk);
    lb_a = 32'd1;
    @(posedge clk); #1;
    n_cmp++; if (err_a !== ERR_ON) begin n_fail++; $display("FAIL miss_err_sticky: got %b want %b", err_a, ERR_ON); end
    n_cmp++; if (outq_a !== 8'hA5) begin n_fail++; $display("FAIL miss_recover_outq: got %h want a5", outq_a); end
    @(negedge clk);
    en_a = 1'b0;
  endtask

  task automatic test_dup_and_width();
    @(negedge clk);
    s_a  = {32'd3, 32'd3};
    in_a = {8'h22, 8'h11};
    lb_a = 32'd3;
    #1;
    n_cmp++; if (out_a !== 8'h11) begin n_fail++; $display("FAIL dup_out: got %h want 11", out_a); end
    n_cmp++; if (miss_a !== 1'b0) begin n_fail++; $display("FAIL dup_miss: got %b want 0", miss_a); end
    // ids differing only in the top bit must not match
    s_a  = {32'h8000_0003, 32'h0000_0002};
    #1;
    n_cmp++; if (miss_a !== 1'b1) begin n_fail++; $display("FAIL width_msb_miss: got %b want 1", miss_a); end
    n_cmp++; if (out_a !== 8'h00) begin n_fail++; $display("FAIL width_msb_out: got %h want 00", out_a); end
    lb_a = 32'h8000_0003;
    #1;
    n_cmp++; if (out_a !== 8'h22) begin n_fail++; $display("FAIL width_msb_hit: got %h want 22", out_a); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    s_a  = {32'd1, 32'd0};
    in_a = {8'hA5, 8'h5A};
    lb_a = 32'd0;
    en_a = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (outq_a !== 8'h5A) begin n_fail++; $display("FAIL ar_pre_outq: got %h want 5a", outq_a); end
    n_cmp++; if (err_a !== ERR_ON) begin n_fail++; $display("FAIL ar_pre_err: got %b want %b", err_a, ERR_ON); end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (outq_a !== 8'h00) begin n_fail++; $display("FAIL ar_outq_async: got %h want 00", outq_a); end
    n_cmp++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL ar_err_async: got %b want 0", err_a); end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      n_cmp++; if (outq_a !== 8'h00) begin n_fail++; $display("FAIL ar_no_capture: got %h want 00", outq_a); end
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (outq_a !== 8'h5A) begin n_fail++; $display("FAIL ar_resume: got %h want 5a", outq_a); end
    n_cmp++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL ar_err_after: got %b want 0", err_a); end
    @(negedge clk);
    en_a = 1'b0;
  endtask

  task automatic test_sweep_wide();
    logic [31:0] lbs [4];
    logic [15:0] exp [4];
    lbs = '{32'd0, 32'd10, 32'd20, 32'd30};
    exp = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    @(negedge clk);
    s_b  = {32'd30, 32'd20, 32'd10, 32'd0};
    in_b = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      lb_b = lbs[k];
      en_b = 1'b1;
      #1;
      n_cmp++; if (out_b !== exp[k]) begin n_fail++; $display("FAIL sweep_out[%0d]: got %h want %h", k, out_b, exp[k]); end
      n_cmp++; if (miss_b !== 1'b0) begin n_fail++; $display("FAIL sweep_miss[%0d]: got %b want 0", k, miss_b); end
      @(posedge clk); #1;
      n_cmp++; if (outq_b !== exp[k]) begin n_fail++; $display("FAIL sweep_outq[%0d]: got %h want %h", k, outq_b, exp[k]); end
    end
    @(negedge clk);
    en_b = 1'b0;
    lb_b = 32'd5;
    #1;
    n_cmp++; if (miss_b !== 1'b1) begin n_fail++; $display("FAIL sweep_nomatch_miss: got %b want 1", miss_b); end
    n_cmp++; if (out_b !== 16'h0000) begin n_fail++; $display("FAIL sweep_nomatch_out: got %h want 0000", out_b); end
    @(posedge clk); #1;
    n_cmp++; if (outq_b !== 16'h4444) begin n_fail++; $display("FAIL sweep_hold: got %h want 4444", outq_b); end
    n_cmp++; if (err_b !== 1'b0) begin n_fail++; $display("FAIL sweep_err_b: got %b want 0", err_b); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_select();
    test_capture();
    test_miss();
    test_dup_and_width();
    test_async_reset();
    test_sweep_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/phi.md
PHI -- requirements
Module: phi

Interface
REQ-001 Parameter NB_PAIR, default 2: number of (predecessor-block, value) pairs; legal range 1..16.
REQ-002 Parameter WIDTH, default 8: bit width of each candidate value and of the result.
REQ-003 Parameter BB_WIDTH, default 32: bit width of basic-block identifiers.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-low.
REQ-006 Port in, input, NB_PAIR*WIDTH: packed candidate values; pair i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port s, input, NB_PAIR*BB_WIDTH: packed predecessor block ids; pair i occupies bits [i*BB_WIDTH +: BB_WIDTH].
REQ-008 Port last_block, input, BB_WIDTH: id of the block control arrived from.
REQ-009 Port en, input, 1: capture strobe for the registered result.
REQ-010 Port out, output, WIDTH: combinational selected value.
REQ-011 Port out_q, output, WIDTH: registered selected value.
REQ-012 Port miss, output, 1: combinational flag, high when no pair matches last_block.
REQ-013 Port err, output, 1: sticky mismatch error flag (see Configuration).

Function
REQ-014 Pair i matches when s slice i equals last_block, compared over all BB_WIDTH bits.
REQ-015 out SHALL equal the in slice of the lowest-index matching pair, with zero cycles of latency.
REQ-016 Duplicate ids in s: the lowest index wins, and miss stays low.
REQ-017 No match: out SHALL be all zeros and miss SHALL be 1.
REQ-018 On a rising clk edge with en=1, out_q SHALL load out.
REQ-019 With en=0, out_q SHALL hold its value; there is no other state-update path.
REQ-020 Capture with en=1 and miss=1: out_q SHALL load zero.
REQ-021 There is no handshake; out, miss, out_q and err have no valid qualifier.
REQ-022 Inputs change asynchronously to en; only values present at the sampling edge matter for out_q and err.

Reset
REQ-023 While rst=0: out_q=0 and err=0 immediately, without waiting for a clock edge.
REQ-024 Reset dominates en; captures resume on the first rising edge after rst returns to 1.
REQ-025 Reset does not affect the combinational outputs out and miss.

Configuration
REQ-026 Macro PHI_MISS_CHECK_EN defined: err SHALL set to 1 on a rising edge with en=1 and miss=1.
REQ-027 With PHI_MISS_CHECK_EN defined, err SHALL stay set until reset.
REQ-028 Macro PHI_MISS_CHECK_EN undefined: err SHALL be constant 0 and no error register is built.

Structure
REQ-029 A shared package phi_pkg SHALL hold the BB_WIDTH default constant, the block-id typedef (bb_id_t) and the max-pairs constant (16).
REQ-030 One sub-module, phi_match, SHALL compute the NB_PAIR-wide match vector.
REQ-031 The priority select, output register and error register stay in phi.

Verification
REQ-032 NB_PAIR=2, in={8'hA5,8'h00}, s={1,0}, last_block=0 -> out=8'h00, miss=0; last_block=1 -> out=8'hA5.
REQ-033 Same inputs with last_block=1, en pulsed one cycle -> out_q=8'hA5 after the edge; out_q holds 8'hA5 after in changes while en=0.
REQ-034 last_block=7 (no match), en=1 -> miss=1, out=0, out_q=0; err=1 with PHI_MISS_CHECK_EN defined, err=0 without it.
REQ-035 s={3,3}, in={8'h22,8'h11}, last_block=3 -> out=8'h11 (index 0 wins), miss=0.
REQ-036 err=1 and out_q=8'h5A, then rst driven low between clock edges -> out_q=0 and err=0 before the next edge; en=1 held during reset causes no capture.
REQ-037 NB_PAIR=4, WIDTH=16, s={30,20,10,0}, sweep last_block over 0,10,20,30 -> out tracks the matching slice on each step.
